// File: rtl/hsid_dist_unit.sv
// hsid_dist_unit
//   Spectral distance engine. Takes pairs of packed pixel and library words,
//   accumulates per-band MSE terms (diff^2) or MAD terms (|diff|) for each
//   vector, and divides the sum by the band count to give the distance. Over
//   a library scan it also tracks the smallest distance and its index.
//   Pipeline: stage 1 |a-b| -> stage 2 accumulate -> restoring divider.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   clear                synchronous flush of datapath, divider and running min
//   mode                 0 = MSE, 1 = MAD (taken from the start beat)
//   hsi_bands            active band count
//   element_*            beat handshake, framing and packed operands
//   vctr_ref             library index (taken from the start beat)
//   mse_value/ref/valid  per-vector distance and its one-cycle strobe
//   min_value/ref/valid  scan minimum and its one-cycle strobe
module hsid_dist_unit #(
  parameter int WORD_WIDTH       = 32,
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_WIDTH_MUL   = 32,
  parameter int DATA_WIDTH_ACC   = 48,
  parameter int HSI_BANDS_MAX    = 128,
  parameter int HSI_LIBRARY_SIZE = 256,
  localparam int REF_W  = $clog2(HSI_LIBRARY_SIZE),
  localparam int BAND_W = $clog2(HSI_BANDS_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  mode,
  input  logic [BAND_W-1:0]     hsi_bands,
  input  logic                  element_valid,
  output logic                  element_ready,
  input  logic                  element_start,
  input  logic                  element_last,
  input  logic                  scan_last,
  input  logic [REF_W-1:0]      vctr_ref,
  input  logic [WORD_WIDTH-1:0] element_a,
  input  logic [WORD_WIDTH-1:0] element_b,
  output logic [WORD_WIDTH-1:0] mse_value,
  output logic [REF_W-1:0]      mse_ref,
  output logic                  mse_valid,
  output logic [WORD_WIDTH-1:0] min_value,
  output logic [REF_W-1:0]      min_ref,
  output logic                  min_valid
);
  localparam int DPW   = WORD_WIDTH / DATA_WIDTH;
  localparam int ACC   = DATA_WIDTH_ACC;
  localparam int IDX_W = 16;
  localparam int CNT_W = $clog2(ACC + 1);

  // framing and stage 1
  logic                             vec_open_q, vec_mode_q;
  logic [IDX_W-1:0]                 beat_idx_q, cur_idx, lane_idx;
  logic [REF_W-1:0]                 vec_ref_q, cur_ref;
  logic                             cur_mode, stall, beat_take;
  logic [DPW-1:0][DATA_WIDTH-1:0]   lane_a, lane_b, lane_diff;
  logic                             s1_valid_q, s1_start_q, s1_last_q, s1_scan_q, s1_mode_q;
  logic [REF_W-1:0]                 s1_ref_q;
  logic [BAND_W-1:0]                s1_bands_q;
  logic [DPW-1:0][DATA_WIDTH-1:0]   s1_diff_q;
  // stage 2
  logic [ACC-1:0]                   term, acc_q, acc_base, acc_next;
  logic [ACC:0]                     acc_sum;
  logic                             acc_sat_q, sat_next, acc_done_q, done_scan_q;
  logic [REF_W-1:0]                 done_ref_q;
  logic [BAND_W-1:0]                done_bands_q;
  // divider and arg-min
  logic                             div_busy_q, div_scan_q, div_load, div_final, rem_ge;
  logic [CNT_W-1:0]                 div_cnt_q;
  logic [ACC-1:0]                   div_quo_q, quo_nx;
  logic [BAND_W-1:0]                div_rem_q, div_den_q, rem_nx;
  logic [BAND_W:0]                  rem_trial, rem_sub;
  logic [REF_W-1:0]                 div_ref_q, cand_ref;
  logic [WORD_WIDTH-1:0]            result, cand_val;
  logic                             rmin_valid_q;
  logic [WORD_WIDTH-1:0]            rmin_value_q, mse_value_q, min_value_q;
  logic [REF_W-1:0]                 rmin_ref_q, mse_ref_q, min_ref_q;
  logic                             mse_valid_q, min_valid_q;

  // A finished sum waiting on a busy divider freezes stages 1-2.
  assign stall         = acc_done_q && div_busy_q;
  assign element_ready = !stall;
  // Beats outside an open vector are dropped; clear wins over a beat.
  assign beat_take = element_valid && !stall && !clear && (element_start || vec_open_q);
  assign cur_idx   = element_start ? '0 : beat_idx_q;
  assign cur_mode  = element_start ? mode : vec_mode_q;
  assign cur_ref   = element_start ? vctr_ref : vec_ref_q;

  always_comb begin
    lane_a    = element_a[DPW*DATA_WIDTH-1:0];
    lane_b    = element_b[DPW*DATA_WIDTH-1:0];
    lane_diff = '0;
    lane_idx  = '0;
    for (int k = 0; k < DPW; k++) begin
      lane_idx     = cur_idx * IDX_W'(DPW) + IDX_W'(k);
      lane_diff[k] = (lane_a[k] > lane_b[k]) ? lane_a[k] - lane_b[k] : lane_b[k] - lane_a[k];
      if (lane_idx >= IDX_W'(hsi_bands)) lane_diff[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_open_q <= 1'b0;
      vec_mode_q <= 1'b0;
      vec_ref_q  <= '0;
      beat_idx_q <= '0;
      s1_valid_q <= 1'b0;
      s1_start_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_scan_q  <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_ref_q   <= '0;
      s1_bands_q <= '0;
      s1_diff_q  <= '0;
    end else if (clear) begin
      vec_open_q <= 1'b0;
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= beat_take;
      if (beat_take) begin
        vec_open_q <= !element_last;
        vec_mode_q <= cur_mode;
        vec_ref_q  <= cur_ref;
        beat_idx_q <= (cur_idx == '1) ? cur_idx : cur_idx + 1'b1;
        s1_start_q <= element_start;
        s1_last_q  <= element_last;
        s1_scan_q  <= scan_last && element_last;
        s1_mode_q  <= cur_mode;
        s1_ref_q   <= cur_ref;
        s1_bands_q <= hsi_bands;
        s1_diff_q  <= lane_diff;
      end
    end
  end

  always_comb begin
    term = '0;
    for (int k = 0; k < DPW; k++) begin
      if (s1_mode_q) term = term + ACC'(s1_diff_q[k]);
      else term = term + ACC'(DATA_WIDTH_MUL'(s1_diff_q[k]) * DATA_WIDTH_MUL'(s1_diff_q[k]));
    end
  end

  // Saturation is sticky across beats of a vector; a start beat restarts it.
  assign acc_base = s1_start_q ? '0 : acc_q;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, term};
  assign sat_next = (!s1_start_q && acc_sat_q) || acc_sum[ACC];
  assign acc_next = sat_next ? '1 : acc_sum[ACC-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      acc_sat_q    <= 1'b0;
      acc_done_q   <= 1'b0;
      done_ref_q   <= '0;
      done_scan_q  <= 1'b0;
      done_bands_q <= '0;
    end else if (clear) begin
      acc_q      <= '0;
      acc_sat_q  <= 1'b0;
      acc_done_q <= 1'b0;
    end else if (!stall) begin
      acc_done_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        acc_q     <= acc_next;
        acc_sat_q <= sat_next;
      end
      if (s1_valid_q && s1_last_q) begin
        done_ref_q   <= s1_ref_q;
        done_scan_q  <= s1_scan_q;
        done_bands_q <= s1_bands_q;
      end
    end
  end

  // Restoring divide: dividend bits shift out of the top of div_quo_q while
  // quotient bits shift in at the bottom. A zero divisor yields all ones.
  assign div_load  = acc_done_q && !div_busy_q;
  assign div_final = div_busy_q && (div_cnt_q == CNT_W'(1));
  assign rem_trial = {div_rem_q, div_quo_q[ACC-1]};
  assign rem_sub   = rem_trial - {1'b0, div_den_q};
  assign rem_ge    = rem_trial >= {1'b0, div_den_q};
  assign rem_nx    = rem_ge ? rem_sub[BAND_W-1:0] : rem_trial[BAND_W-1:0];
  assign quo_nx    = {div_quo_q[ACC-2:0], rem_ge};
  assign result    = (|(quo_nx >> WORD_WIDTH)) ? '1 : quo_nx[WORD_WIDTH-1:0];
  // Strict compare: ties keep the earlier library vector.
  assign cand_val  = (!rmin_valid_q || result < rmin_value_q) ? result : rmin_value_q;
  assign cand_ref  = (!rmin_valid_q || result < rmin_value_q) ? div_ref_q : rmin_ref_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy_q   <= 1'b0;
      div_cnt_q    <= '0;
      div_quo_q    <= '0;
      div_rem_q    <= '0;
      div_den_q    <= '0;
      div_ref_q    <= '0;
      div_scan_q   <= 1'b0;
      rmin_valid_q <= 1'b0;
      rmin_value_q <= '0;
      rmin_ref_q   <= '0;
      mse_valid_q  <= 1'b0;
      mse_value_q  <= '0;
      mse_ref_q    <= '0;
      min_valid_q  <= 1'b0;
      min_value_q  <= '0;
      min_ref_q    <= '0;
    end else if (clear) begin
      div_busy_q   <= 1'b0;
      rmin_valid_q <= 1'b0;
      mse_valid_q  <= 1'b0;
      min_valid_q  <= 1'b0;
    end else begin
      mse_valid_q <= 1'b0;
      min_valid_q <= 1'b0;
      if (div_load) begin
        div_busy_q <= 1'b1;
        div_cnt_q  <= CNT_W'(ACC);
        div_quo_q  <= acc_q;
        div_rem_q  <= '0;
        div_den_q  <= done_bands_q;
        div_ref_q  <= done_ref_q;
        div_scan_q <= done_scan_q;
      end else if (div_busy_q) begin
        div_quo_q <= quo_nx;
        div_rem_q <= rem_nx;
        div_cnt_q <= div_cnt_q - 1'b1;
        if (div_final) begin
          div_busy_q  <= 1'b0;
          mse_valid_q <= 1'b1;
          mse_value_q <= result;
          mse_ref_q   <= div_ref_q;
          if (div_scan_q) begin
            min_valid_q  <= 1'b1;
            min_value_q  <= cand_val;
            min_ref_q    <= cand_ref;
            rmin_valid_q <= 1'b0;
          end else begin
            rmin_valid_q <= 1'b1;
            rmin_value_q <= cand_val;
            rmin_ref_q   <= cand_ref;
          end
        end
      end
    end
  end

  assign mse_value = mse_value_q;
  assign mse_ref   = mse_ref_q;
  assign mse_valid = mse_valid_q;
  assign min_value = min_value_q;
  assign min_ref   = min_ref_q;
  assign min_valid = min_valid_q;

endmodule

// File: tb/tb_hsid_dist_unit.sv
module tb_hsid_dist_unit;
  localparam int ACC  = 48;
  localparam int ACC2 = 36;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, mode = 1'b0, sel2 = 1'b0;
  logic [7:0]  hsi_bands = 8'd4;
  logic        element_valid = 1'b0, element_start = 1'b0, element_last = 1'b0, scan_last = 1'b0;
  logic [7:0]  vctr_ref = '0;
  logic [31:0] element_a = '0, element_b = '0;

  logic        v1, v2, ready1, ready2, mse_valid1, mse_valid2, min_valid1, min_valid2;
  logic [31:0] mse_value1, mse_value2, min_value1, min_value2;
  logic [7:0]  mse_ref1, mse_ref2, min_ref1, min_ref2;

  assign v1 = element_valid && !sel2;
  assign v2 = element_valid && sel2;

  hsid_dist_unit dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .hsi_bands(hsi_bands),
    .element_valid(v1), .element_ready(ready1), .element_start(element_start),
    .element_last(element_last), .scan_last(scan_last), .vctr_ref(vctr_ref),
    .element_a(element_a), .element_b(element_b),
    .mse_value(mse_value1), .mse_ref(mse_ref1), .mse_valid(mse_valid1),
    .min_value(min_value1), .min_ref(min_ref1), .min_valid(min_valid1));

  hsid_dist_unit #(.DATA_WIDTH_ACC(ACC2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .hsi_bands(hsi_bands),
    .element_valid(v2), .element_ready(ready2), .element_start(element_start),
    .element_last(element_last), .scan_last(scan_last), .vctr_ref(vctr_ref),
    .element_a(element_a), .element_b(element_b),
    .mse_value(mse_value2), .mse_ref(mse_ref2), .mse_valid(mse_valid2),
    .min_value(min_value2), .min_ref(min_ref2), .min_valid(min_valid2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    logic [7:0]  rf;
    int          cyc;   // 0 = strobe cycle not checked
    bit          gap;   // check spacing from the previous strobe
  } exp_t;

  exp_t q1[$], q2[$], qmin[$];
  int   checks = 0, errors = 0;
  int   last_strobe = 0;
  bit   saw_low = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] pk(input logic [15:0] l0, input logic [15:0] l1);
    return {l1, l0};
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (mse_valid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe actual=%0h ref=%0h required=none", mse_value1, mse_ref1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("mse_value", mse_value1, e.val);
        chk("mse_ref", mse_ref1, e.rf);
        if (e.cyc > 0) chk("latency", cyc, e.cyc);
        if (e.gap) chk("strobe_gap_ge_acc", ((cyc - last_strobe) >= ACC), 1);
      end
      last_strobe = cyc;
    end
    if (min_valid1) begin
      if (qmin.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_min actual=%0h ref=%0h required=none", min_value1, min_ref1);
      end else begin
        exp_t e;
        e = qmin.pop_front();
        chk("min_value", min_value1, e.val);
        chk("min_ref", min_ref1, e.rf);
      end
    end
    if (!ready1) saw_low = 1'b1;
  end

  always @(negedge clk) begin
    if (mse_valid2 || min_valid2) begin
      if (q2.size() == 0 || min_valid2) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe_acc36 actual=%0h required=none", mse_value2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("sat_value", mse_value2, e.val);
        chk("sat_ref", mse_ref2, e.rf);
        chk("sat_latency", cyc, e.cyc);
      end
    end
  end

  // Drive one beat and hold it until accepted; t = cycle in which it transferred.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit st, input bit ls,
                      input bit sl, input logic [7:0] rf, output int t);
    bit rdy, done;
    element_a = a; element_b = b; element_start = st; element_last = ls;
    scan_last = sl; vctr_ref = rf; element_valid = 1'b1;
    done = 1'b0; t = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      rdy = sel2 ? ready2 : ready1;
      t = cyc;
      @(posedge clk);
      done = rdy;
    end
    #1;
    element_valid = 1'b0; element_start = 1'b0; element_last = 1'b0; scan_last = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((q1.size() + q2.size() + qmin.size()) != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if ((q1.size() + q2.size() + qmin.size()) != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q1.size() + q2.size() + qmin.size());
      q1.delete(); q2.delete(); qmin.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // one-beat MAD vectors for the arg-min scans (bands = 1, lane 1 masked)
  logic [31:0] scan_val [6] = '{32'd9, 32'd4, 32'd4, 32'd7, 32'd12, 32'd11};
  logic [7:0]  scan_ref [6] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd20, 8'd21};
  logic [31:0] b3_a     [3];
  logic [31:0] b3_exp   [3] = '{32'd2, 32'd5, 32'd16};

  initial begin
    int t;
    b3_a[0] = pk(16'd2, 16'd0);
    b3_a[1] = pk(16'd3, 16'd1);
    b3_a[2] = pk(16'd4, 16'd4);

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mse_value", mse_value1, 0);
    chk("rst_mse_ref", mse_ref1, 0);
    chk("rst_mse_valid", mse_valid1, 0);
    chk("rst_min_value", min_value1, 0);
    chk("rst_min_valid", min_valid1, 0);
    chk("rst_ready", ready1, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // MSE, 4 bands: (4+0+16+16)/4 = 9, strobe at T+3+ACC
    mode = 1'b0; hsi_bands = 8'd4;
    send(pk(3, 1), pk(1, 1), 1, 0, 0, 8'd5, t);
    send(pk(0, 10), pk(4, 6), 0, 1, 0, 8'd5, t);
    q1.push_back('{32'd9, 8'd5, t + 3 + ACC, 1'b0});
    drain(200);

    // MAD: mode taken from the start beat, (2+0+4+4)/4 = 2
    mode = 1'b1;
    send(pk(3, 1), pk(1, 1), 1, 0, 0, 8'd5, t);
    mode = 1'b0;
    send(pk(0, 10), pk(4, 6), 0, 1, 0, 8'd5, t);
    q1.push_back('{32'd2, 8'd5, t + 3 + ACC, 1'b0});
    drain(200);

    // 3 bands, lane 3 masked: 20/3 = 6
    hsi_bands = 8'd3;
    send(pk(3, 1), pk(1, 1), 1, 0, 0, 8'd5, t);
    send(pk(0, 10), pk(4, 6), 0, 1, 0, 8'd5, t);
    q1.push_back('{32'd6, 8'd5, t + 3 + ACC, 1'b0});
    drain(200);

    // back-to-back one-beat vectors under back-pressure
    hsi_bands = 8'd2;
    saw_low = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(b3_a[i], 32'd0, 1, 1, 0, 8'(i + 1), t);
      q1.push_back('{b3_exp[i], 8'(i + 1), (i == 0) ? t + 3 + ACC : 0, i != 0});
    end
    drain(400);
    chk("ready_dropped", saw_low, 1);

    // arg-min over two scans, fresh running min
    pulse_clear();
    hsi_bands = 8'd1; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(pk(scan_val[i][15:0], 16'd100), 32'd0, 1, 1, (i == 3) || (i == 5), scan_ref[i], t);
      q1.push_back('{scan_val[i], scan_ref[i], 0, (i != 0)});
    end
    qmin.push_back('{32'd4, 8'd6, 0, 1'b0});
    qmin.push_back('{32'd11, 8'd21, 0, 1'b0});
    drain(600);

    // accumulator saturation on the 36-bit instance
    sel2 = 1'b1; hsi_bands = 8'd128; mode = 1'b0;
    for (int i = 0; i < 64; i++) send(32'hFFFF_FFFF, 32'd0, i == 0, i == 63, 0, 8'd9, t);
    q2.push_back('{32'h1FFF_FFFF, 8'd9, t + 3 + ACC2, 1'b0});
    drain(200);
    sel2 = 1'b0;

    // zero bands
    hsi_bands = 8'd0;
    send(pk(7, 7), pk(1, 2), 1, 1, 0, 8'd3, t);
    q1.push_back('{32'hFFFF_FFFF, 8'd3, t + 3 + ACC, 1'b0});
    drain(200);

    // clear mid-vector, stray beat with no open vector, then an exact vector
    hsi_bands = 8'd4;
    send(pk(16'hFFFF, 16'hFFFF), pk(0, 0), 1, 0, 0, 8'd44, t);
    pulse_clear();
    send(pk(16'h1234, 16'h10), pk(0, 0), 0, 1, 0, 8'd45, t);
    send(pk(3, 1), pk(1, 1), 1, 0, 0, 8'd7, t);
    send(pk(0, 10), pk(4, 6), 0, 1, 0, 8'd7, t);
    q1.push_back('{32'd9, 8'd7, t + 3 + ACC, 1'b0});
    drain(200);

    // clear mid-division: no strobe, ready high
    send(pk(5, 5), pk(0, 0), 1, 1, 0, 8'd50, t);
    idle(10);
    pulse_clear();
    @(negedge clk);
    chk("clear_ready", ready1, 1);
    idle(70);

    // reset mid-division
    send(pk(6, 6), pk(0, 0), 1, 1, 0, 8'd51, t);
    idle(10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mse_value", mse_value1, 0);
    chk("midrst_mse_ref", mse_ref1, 0);
    chk("midrst_min_value", min_value1, 0);
    chk("midrst_min_ref", min_ref1, 0);
    chk("midrst_ready", ready1, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(70);

    // exact result after the reset
    send(pk(3, 1), pk(1, 1), 1, 0, 0, 8'd12, t);
    send(pk(0, 10), pk(4, 6), 0, 1, 0, 8'd12, t);
    q1.push_back('{32'd9, 8'd12, t + 3 + ACC, 1'b0});
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
